// File: rtl/aes_cipher_if.sv
// ============================================================================
// Module  : aes_cipher_if
// Brief   : Request/result bundle between an AES-128 cipher and its client.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_cipher_if;
  logic         start;
  logic [127:0] block_in;
  logic [127:0] key_in;
  logic [127:0] result_out;
  logic         valid_out;
  logic         busy_out;

  modport master (
    output start, block_in, key_in,
    input  result_out, valid_out, busy_out
  );

  modport slave (
    input  start, block_in, key_in,
    output result_out, valid_out, busy_out
  );
endinterface

`default_nettype wire

// File: rtl/aes_cipher.sv
// ============================================================================
// Module  : aes_cipher
// Brief   : Iterative AES-128 encryptor, one round per clock, round keys
//           expanded on the fly.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_cipher #(
  parameter int NUM_ROUNDS = 10
) (
  input wire          clk_in,
  input wire          rst_in,
  aes_cipher_if.slave bus
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ROUND = 1'b1
  } fsm_t;

  fsm_t         r_fsm;
  fsm_t         w_fsm_next;
  logic         w_load;
  logic         w_done;
  logic [127:0] r_state;
  logic [127:0] r_key;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;
  logic [127:0] r_result;
  logic         r_valid;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_key_next;
  logic [127:0] w_state_next;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return c_sbox[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes followed by ShiftRows: output (row r, col c) takes input (r, c+r).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-32*c-8*r -: 8] = sbox(s[127-32*((c+r)%4)-8*r -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t ^ {rc, 24'h000000};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always_comb begin
    w_sr         = sub_shift(r_state);
    w_mc         = mix_columns(w_sr);
    w_key_next   = next_key(r_key, r_rcon);
    w_state_next = ((r_round == c_last_round) ? w_sr : w_mc) ^ w_key_next;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    w_load     = 1'b0;
    w_done     = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (bus.start) begin
          w_fsm_next = S_ROUND;
          w_load     = 1'b1;
        end
      end
      S_ROUND: begin
        if (r_round == c_last_round) begin
          w_fsm_next = S_IDLE;
          w_done     = 1'b1;
        end
      end
      default: w_fsm_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= '0;
      r_key    <= '0;
      r_rcon   <= '0;
      r_round  <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_load) begin
        // Round 0 is just the initial AddRoundKey with the cipher key.
        r_state <= bus.block_in ^ bus.key_in;
        r_key   <= bus.key_in;
        r_rcon  <= 8'h01;
        r_round <= 4'd1;
      end else if (r_fsm == S_ROUND) begin
        r_state <= w_state_next;
        r_key   <= w_key_next;
        r_rcon  <= xtime(r_rcon);
        r_round <= w_done ? 4'd0 : r_round + 4'd1;
      end
      if (w_done) begin
        r_result <= w_state_next;
      end
    end
  end

  assign bus.result_out = r_result;
  assign bus.valid_out  = r_valid;
  assign bus.busy_out   = (r_fsm == S_ROUND);

endmodule

`default_nettype wire

// File: doc/aes_cipher.md
Name: aes_cipher

Overview:
AES-128 encryption engine (FIPS-197). It is the forward counterpart of the team's decipher block: it takes a 128-bit plaintext block and a 128-bit cipher key and produces the ciphertext. Round keys are expanded on the fly, one per round, so no key table is stored. The block is iterative, computing one full round per clock, and is self-contained: it holds its own S-box function, ShiftRows, MixColumns and key schedule.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds; fixed at 10 for AES-128; other values are unsupported.

Ports:
clk_in  input  1  system clock; all logic on the rising edge
rst_in  input  1  reset, synchronous, active-high
start  input  1  single-cycle request; sampled only in IDLE
block_in  input  128  plaintext; bits [127:120] are input byte 0
key_in  input  128  cipher key; bits [127:120] are key byte 0
result_out  output  128  ciphertext; holds its value until the next completion or reset
valid_out  output  1  one-cycle pulse when result_out is updated
busy_out  output  1  high from the edge that accepts start until the edge that writes result_out

Behaviour:
- Single clock. Reset is synchronous and active-high on rst_in, and the clock port is clk_in.
- Reset values: result_out=0, valid_out=0, busy_out=0, FSM=IDLE, round counter=0.
- Reset mid-operation aborts the block: no valid_out, result_out forced to 0.
- Byte/state mapping: column c (0..3) = bits [127-32c -: 32]. Row r within a column = bits [31-8r -: 8].
- FSM states:
  - IDLE -> ROUND: on start. The same edge (E0) latches state = block_in ^ key_in, round key = key_in, rcon = 8'h01, round = 1, busy_out = 1.
  - ROUND: at each edge E1..E10, compute the next round key from the current round key and rcon.
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
    - state' = AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), new key).
    - MixColumns is skipped when round==10.
    - rcon' = xtime(rcon), giving the sequence 01,02,04,08,10,20,40,80,1b,36.
    - round increments.
  - ROUND -> IDLE: at E10. The same edge sets result_out = final state, valid_out = 1, busy_out = 0.
- Latency: valid_out is high in the cycle following E10, i.e. 10 clocks after the accepting edge.
- valid_out clears on the next edge unconditionally.
- start while busy_out=1 is ignored: no queueing, block_in/key_in not re-sampled.
- start in the cycle valid_out is high is accepted (FSM already IDLE). Peak throughput is one block per 11 clocks.
- block_in/key_in need only be valid in the cycle start is asserted. Later changes have no effect.
- Arithmetic:
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0).
  - MixColumns per column: s0' = 2a^3b^c^d, rotated per FIPS-197. All arithmetic is mod 2^8 in GF(2^8).
- No X on outputs at any time after reset.

Test Plan:
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> result_out 69c4e0d86a7b0430d8cdb78070b4c55a. valid_out high exactly one cycle, 10 clocks after the start edge.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. After the first clock, internal state = 193de3bea0f4e22b9ac68d2ae9f84808 (AddRoundKey round 0).
- All-zero key and plaintext -> 66e94bd4ef8a2c3b884cfa59ca342b2e. Then start with the App. C.1 vectors in the same cycle valid_out is high -> accepted, second result 69c4e0d8... 10 clocks later.
- Start pulsed at clocks 3 and 7 after an accepted start, with different block_in -> ignored. Single valid_out carries the first block's ciphertext. busy_out is high for exactly 10 cycles.
- rst_in asserted at round 5 -> next cycle result_out=0, valid_out=0, busy_out=0. No valid_out afterwards. A following start with App. B vectors produces the correct ciphertext.
- Loopback: 20 random key/plaintext pairs through aes_cipher, then the ciphertext and same key into decipher -> recovered block equals the original plaintext for all 20.
